ped_request_tx: RTL
===================

Name: ped_request_tx

Overview:
- Transmit end of the pedestrian-request interface into the traffic-light controller.
- Conditions the raw board push-button: 2-FF synchroniser, then debounce.
- Turns a debounced press into the active-low request level `buton`.
- Holds the request until the controller serves it (pedestrian green `green_p`), then enforces a lockout before accepting a new press.

Parameters:
- DEBOUNCE_TICKS, 240000, consecutive stable cycles needed to accept a new button level (20 ms at 12 MHz)
- LOCKOUT_TICKS, 24000000, cycles after pedestrian green ends during which presses are ignored (2 s at 12 MHz)
- TIMEOUT_TICKS, 720000000, cycles a request may stay pending before being dropped; used only with REQ_TIMEOUT_EN

Ports:
- clk  input  1  system clock, 12 MHz board oscillator
- reset  input  1  asynchronous, active-low reset
- btn_raw  input  1  raw board button, active-low, asynchronous, bouncy
- green_p  input  1  controller pedestrian-green lamp, same clock domain as clk
- buton  output  1  request to controller, active-low level
- req_pending  output  1  status LED, 1 while a request is waiting to be served
- press_count  output  16  number of accepted presses, saturating
- timeout_pulse  output  1  one-cycle pulse when a pending request is dropped; tied 0 without REQ_TIMEOUT_EN

Behaviour:
- Reset (async, reset=0):
  - State IDLE; buton=1; req_pending=0; press_count=0; timeout_pulse=0.
  - Synchroniser flops and debounced level = 1; all counters = 0; green_p history register = 0.
- Synchroniser: btn_raw passes through two flops. The debounce logic sees only the second flop.
- Debounce:
  - The counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_TICKS-1 the debounced level takes the synchronised level and the counter clears.
  - A 1->0 transition of the debounced level is a one-cycle `press` strobe.
  - Total latency from a clean btn_raw fall to press = 2 + DEBOUNCE_TICKS cycles.
- green_p edges: detected with one history register. Rise = green_p & ~prev; fall = ~green_p & prev.
- FSM states:
  - IDLE: press -> PENDING; that same edge drives buton<=0 and req_pending<=1; press_count increments, saturating at 0xFFFF.
  - PENDING: buton held 0. On green_p rise -> SERVED with buton<=1 and req_pending<=0. Further presses are ignored and not counted.
    - If green_p is already 1 on PENDING entry, the next cycle counts as served (level test, not only the rise).
  - SERVED: wait for green_p fall -> LOCKOUT; lockout counter cleared. Presses are ignored.
  - LOCKOUT: counter increments each cycle. At LOCKOUT_TICKS-1 -> IDLE. A press strobe in the exit cycle is dropped.
- Registered outputs; no combinational path from any input to any output.
- Counter widths: ceil(log2(max tick parameter + 1)) bits each; no wrap is possible within range.
- Reset mid-operation returns immediately to reset values; any pending request is lost (buton=1).
- A button held down permanently yields one press only; the next press needs a debounced release first.

Optional Feature:
- Macro: REQ_TIMEOUT_EN.
- Defined:
  - A timeout counter runs only while in PENDING.
  - At TIMEOUT_TICKS-1 without service: buton<=1, req_pending<=0, timeout_pulse=1 for one cycle, state -> IDLE.
  - If a served condition and the timeout occur in the same cycle, served wins.
- Undefined: no timeout counter; PENDING is held indefinitely; timeout_pulse is constant 0.

Decomposition:
- Package ped_pkg:
  - state encoding IDLE/PENDING/SERVED/LOCKOUT as a 2-bit enum typedef;
  - default tick constants derived from COUNT_TO=12000000 ticks/s;
  - PRESS_CNT_W=16.
- Sub-module btn_debounce:
  - contains the synchroniser and debounce counter;
  - ports clk, reset, btn_raw, level, press;
  - parameter DEBOUNCE_TICKS.
- The FSM, edge detection and counters stay in ped_request_tx.

Test Plan (DEBOUNCE_TICKS=4, LOCKOUT_TICKS=10, TIMEOUT_TICKS=20):
- Bounce rejection: btn_raw toggles every 2 cycles for 20 cycles, then stays 0 -> exactly one press; buton=0 at cycle 6 after the final fall; press_count=1.
- Full cycle: press -> buton=0; green_p rises -> buton=1 next edge. green_p falls -> 10-cycle lockout, then IDLE. A press inside lockout leaves press_count=1 and buton=1.
- Already-green: green_p=1 at press time -> buton low for exactly 1 cycle, then SERVED; state reaches LOCKOUT after green_p falls.
- Held button: btn_raw low for 100 cycles spanning a full service -> press_count=1 and no second request. Release then re-press after lockout -> press_count=2.
- Reset mid-PENDING: reset=0 asynchronously while buton=0 -> buton=1 and req_pending=0 immediately, without waiting for a clk edge; press_count=0.
- REQ_TIMEOUT_EN defined, no green_p: buton=0 for 20 cycles, then buton=1 with timeout_pulse high for 1 cycle. Timeout and green_p rise in the same cycle -> SERVED and no pulse.

Source files
------------

// File: rtl/ped_pkg.sv
//==============================================================================
// Module      : ped_pkg
// Description : Shared state encoding and default timing constants for the
//               pedestrian-request transmitter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVED  = 2'd2,
        LOCKOUT = 2'd3
    } ped_state_t;

    localparam int COUNT_TO               = 12000000;     // ticks per second
    localparam int DEFAULT_DEBOUNCE_TICKS = COUNT_TO / 50; // 20 ms
    localparam int DEFAULT_LOCKOUT_TICKS  = COUNT_TO * 2;  // 2 s
    localparam int DEFAULT_TIMEOUT_TICKS  = COUNT_TO * 60; // 60 s
    localparam int PRESS_CNT_W            = 16;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//==============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser plus stability-counter debounce for an
//               active-low push-button; emits a one-cycle press strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module btn_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int                 c_CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEBOUNCE_TICKS - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_settle;

    assign w_settle = (r_sync2 != r_level) && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_settle) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Strobe is asserted in the cycle whose closing edge commits the 1->0 level
    // change, so the caller can register its reaction on that same edge.
    assign level = r_level;
    assign press = w_settle & ~r_sync2;

endmodule

`default_nettype wire

// File: rtl/ped_request_tx.sv
//==============================================================================
// Module      : ped_request_tx
// Description : Pedestrian-request transmitter: debounced button to held
//               active-low request, released on pedestrian green, then lockout.
//               Optional pending-request timeout enabled by REQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ped_request_tx
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter int LOCKOUT_TICKS  = DEFAULT_LOCKOUT_TICKS,
    parameter int TIMEOUT_TICKS  = DEFAULT_TIMEOUT_TICKS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_raw,
    input  logic                   green_p,
    output logic                   buton,
    output logic                   req_pending,
    output logic [PRESS_CNT_W-1:0] press_count,
    output logic                   timeout_pulse
);

    localparam int                  c_LOCK_W    = $clog2(LOCKOUT_TICKS + 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCKOUT_TICKS - 1);

    ped_state_t             r_state, w_state_next;
    logic                   r_buton, w_buton_next;
    logic                   r_req, w_req_next;
    logic [PRESS_CNT_W-1:0] r_press_count, w_press_count_next;
    logic [c_LOCK_W-1:0]    r_lock_cnt, w_lock_cnt_next;
    logic                   r_green_prev;
    logic                   w_green_fall;
    logic                   w_press;
    logic                   w_level;
    logic                   w_unused;

`ifdef REQ_TIMEOUT_EN
    localparam int                 c_TMO_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_TICKS - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_next;
    logic               r_tmo_pulse, w_tmo_pulse_next;
`endif

    btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .level   (w_level),
        .press   (w_press)
    );

    assign w_green_fall = ~green_p & r_green_prev;
    assign w_unused     = ^{w_level, TIMEOUT_TICKS[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_buton       <= 1'b1;
            r_req         <= 1'b0;
            r_press_count <= '0;
            r_lock_cnt    <= '0;
            r_green_prev  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_buton       <= w_buton_next;
            r_req         <= w_req_next;
            r_press_count <= w_press_count_next;
            r_lock_cnt    <= w_lock_cnt_next;
            r_green_prev  <= green_p;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_buton_next       = r_buton;
        w_req_next         = r_req;
        w_press_count_next = r_press_count;
        w_lock_cnt_next    = r_lock_cnt;
`ifdef REQ_TIMEOUT_EN
        w_tmo_cnt_next     = '0;
        w_tmo_pulse_next   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_state_next = PENDING;
                    w_buton_next = 1'b0;
                    w_req_next   = 1'b1;
                    if (r_press_count != '1) begin
                        w_press_count_next = r_press_count + 1'b1;
                    end
                end
            end
            PENDING: begin
                // Level test so a green already lit on entry serves at once;
                // also gives service priority over a coincident timeout.
                if (green_p) begin
                    w_state_next = SERVED;
                    w_buton_next = 1'b1;
                    w_req_next   = 1'b0;
                end
`ifdef REQ_TIMEOUT_EN
                else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_state_next     = IDLE;
                    w_buton_next     = 1'b1;
                    w_req_next       = 1'b0;
                    w_tmo_pulse_next = 1'b1;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + 1'b1;
                end
`endif
            end
            SERVED: begin
                if (w_green_fall) begin
                    w_state_next    = LOCKOUT;
                    w_lock_cnt_next = '0;
                end
            end
            LOCKOUT: begin
                if (r_lock_cnt == c_LOCK_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_lock_cnt_next = r_lock_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef REQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt   <= '0;
            r_tmo_pulse <= 1'b0;
        end else begin
            r_tmo_cnt   <= w_tmo_cnt_next;
            r_tmo_pulse <= w_tmo_pulse_next;
        end
    end

    assign timeout_pulse = r_tmo_pulse;
`else
    assign timeout_pulse = 1'b0;
`endif

    assign buton       = r_buton;
    assign req_pending = r_req;
    assign press_count = r_press_count;

endmodule

`default_nettype wire
